// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, port
// identifiers, memory access size codes and the default bus timeout.
package mem_port_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } arb_state_t;

    // Requesting port identifiers; also the encoding of last_grant
    typedef enum logic {
        PORT_D  = 1'b0,
        PORT_IF = 1'b1
    } port_t;

    // Memory access size codes carried on m_size / d_size
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Bus cycles without m_ack before a transaction is aborted
    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Bus watchdog: counts cycles spent in the BUS state and flags the cycle in
// which the count reaches the timeout limit.
module mem_arb_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // cnt holds (bus cycle number - 1), so the Nth bus cycle compares against N-1
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    // Cycle counter: cleared while idle, advances once per bus cycle, saturates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch (IF) and data (D) ports share a
// single memory bus. Round-robin on ties, one transaction in flight, with a
// bus watchdog that aborts a transaction that never sees m_ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter logic        RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    input  logic        d_sext,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    output logic        m_sext,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,

    output logic        busy,
    output logic        err
);

    arb_state_t  state;
    port_t       owner;
    port_t       last_grant;
    logic        win_if;
    logic        timer_clr;
    logic        timer_en;
    logic        expired;
    logic [31:0] done_data;

    // IF wins when alone, or on a tie when data was granted last
    assign win_if    = if_req && (!d_req || (last_grant == PORT_D));

    assign timer_clr = (state == ST_IDLE);
    assign timer_en  = (state == ST_BUS);

    // An ack in the expiry cycle takes precedence: normal completion
    assign done_data = m_ack ? m_rdata : '0;

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    // Arbitration FSM with all outputs registered; pulses default low each cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            owner      <= PORT_D;
            last_grant <= port_t'(RR_INIT);
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_rvalid   <= 1'b0;
            d_rdata    <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_size     <= '0;
            m_sext     <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // m_ack is ignored here; only pending requests matter
                    if (if_req || d_req) begin
                        state <= ST_BUS;
                        busy  <= 1'b1;
                        m_req <= 1'b1;
                        if (win_if) begin
                            owner      <= PORT_IF;
                            last_grant <= PORT_IF;
                            if_gnt     <= 1'b1;
                            m_we       <= 1'b0;
                            m_addr     <= if_addr;
                            m_wdata    <= '0;
                            m_size     <= SIZE_WORD;
                            m_sext     <= 1'b0;
                        end else begin
                            owner      <= PORT_D;
                            last_grant <= PORT_D;
                            d_gnt      <= 1'b1;
                            m_we       <= d_we;
                            m_addr     <= d_addr;
                            m_wdata    <= d_wdata;
                            m_size     <= d_size;
                            m_sext     <= d_sext;
                        end
                    end
                end

                ST_BUS: begin
                    // Requests are not re-sampled here: a dropped req still completes
                    if (m_ack || expired) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        m_req <= 1'b0;
                        err   <= !m_ack;
                        if (owner == PORT_IF) begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= done_data;
                        end else begin
                            d_rvalid  <= 1'b1;
                            d_rdata   <= done_data;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: bus cycles without ack before abort.
REQ-002 SHALL have parameter RR_INIT, default 0: last-grant value after reset (0 = data last, so the IF port wins the first tie).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port if_req, input, 1 bit: instruction fetch request, held until if_rvalid.
REQ-007 SHALL have port if_addr, input, 32 bits: fetch address.
REQ-008 SHALL have port if_gnt, output, 1 bit: one-cycle pulse when the fetch is accepted.
REQ-009 SHALL have port if_rvalid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port if_rdata, output, 32 bits: fetched word, valid with if_rvalid.
REQ-011 SHALL have port d_req, input, 1 bit: data request, held until d_rvalid.
REQ-012 SHALL have port d_we, input, 1 bit: 1 = write.
REQ-013 SHALL have port d_addr, input, 32 bits: data address.
REQ-014 SHALL have port d_wdata, input, 32 bits: write data.
REQ-015 SHALL have port d_size, input, 2 bits: 0 = byte, 1 = half, 2 = word.
REQ-016 SHALL have port d_sext, input, 1 bit: sign-extend load.
REQ-017 SHALL have port d_gnt, output, 1 bit: one-cycle accept pulse.
REQ-018 SHALL have port d_rvalid, output, 1 bit: one-cycle completion pulse, for reads and writes.
REQ-019 SHALL have port d_rdata, output, 32 bits: load data.
REQ-020 SHALL have outputs m_req (1), m_we (1), m_addr (32), m_wdata (32), m_size (2), m_sext (1): shared memory bus.
REQ-021 SHALL have inputs m_ack (1) and m_rdata (32): memory completion and read data.
REQ-022 SHALL have outputs busy (1), err (1): transaction in flight; one-cycle timeout pulse.

Function
REQ-023 SHALL implement the FSM IDLE -> BUS -> IDLE, with every output registered.
REQ-024 In IDLE with at least one request pending, SHALL select the winner, capture its attributes, pulse its gnt, and enter BUS at the same edge, so gnt and m_req rise one cycle after req is sampled.
REQ-025 When both requests are pending in the same cycle, SHALL grant the port not granted last (round-robin); last_grant updates on every grant.
REQ-026 SHALL hold m_req and all captured m_* attributes constant for the whole BUS state.
REQ-027 IF grants SHALL drive m_we=0, m_size=2 and m_sext=0.
REQ-028 On m_ack in BUS, SHALL drop m_req, pulse the winner's rvalid with rdata=m_rdata, and return to IDLE at that edge; the completion therefore appears one cycle after the ack.
REQ-029 SHALL allow back-to-back transactions: a request pending in the first IDLE cycle after completion is granted at the next edge, so the bus sits idle for at least one cycle between transactions.
REQ-030 SHALL hold the non-winning port's rdata and rvalid at 0.
REQ-031 SHALL count cycles in BUS with an 8-bit counter; when the count reaches TIMEOUT without m_ack, SHALL drop m_req, pulse rvalid with rdata=0 and err=1, and return to IDLE.
REQ-032 When m_ack arrives in the same cycle the count reaches TIMEOUT, SHALL treat the ack as the winner: normal completion, no err.
REQ-033 A req that deasserts during BUS is a protocol violation; the transaction SHALL still complete normally.
REQ-034 SHALL ignore m_ack while in IDLE.
REQ-035 SHALL drive busy=1 exactly while in BUS.

Reset
REQ-036 While rst=0, SHALL immediately force state=IDLE, all outputs=0, counter=0 and last_grant=RR_INIT, including mid-transaction.
REQ-037 SHALL produce no rvalid for a transaction aborted by reset.

Structure
REQ-038 SHALL define the state encoding, the size codes and the default TIMEOUT in the shared define package.
REQ-039 SHALL implement the timeout counter as one sub-module, mem_arb_timer (inputs clr and en; output expired).

Verification
REQ-040 Scenario: lone if_req at address 0x100, m_ack on the 3rd bus cycle with rdata 0xDEADBEEF -> if_gnt at cycle 1, if_rvalid=1 with 0xDEADBEEF one cycle after the ack, d_rvalid=0 throughout.
REQ-041 Scenario: if_req and d_req in the same cycle, three times in a row -> grant order after reset is IF, D, IF.
REQ-042 Scenario: d_req write, address 0x2000, wdata 0x55, size 0 -> m_we=1, m_size=0, m_wdata=0x55 stable until m_ack, then one d_rvalid pulse.
REQ-043 Scenario: TIMEOUT=4, no ack -> m_req high for exactly 4 cycles, then err, d_rvalid and rdata=0 in the same cycle.
REQ-044 Scenario: m_ack coincident with the timeout cycle -> normal completion, err=0.
REQ-045 Scenario: rst driven to 0 during BUS -> m_req=0 and busy=0 before the next clock edge, no rvalid; after release, the first tie goes to IF.
